mips_multicycle_ctrl: RTL
=========================

// Module: mips_multicycle_ctrl
// PURPOSE
//  Main control unit of the multi-cycle, non-pipelined MIPS core. A Moore FSM
//  that sequences the shared datapath: one ALU, one unified memory port, IR, A/B/ALUOut
//  regs and register file. Walks each instruction through fetch/decode/execute/
//  writeback, stalls on the memory handshake and counts retired instructions.
// PARAMETERS
//  CNT_WIDTH   32   width of retired-instruction counter (wraps)
// PORTS
//  clk          in   1     core clock, single clock domain
//  rst          in   1     asynchronous, active-high reset
//  opcode       in   6     IR[31:26], stable from DECODE until next FETCH
//  funct        in   6     IR[5:0]
//  mem_ready    in   1     memory completes current read/write this cycle
//  mem_read     out  1     memory read request
//  mem_write    out  1     memory write request
//  iord         out  1     0: address=PC, 1: address=ALUOut
//  ir_write     out  1     load IR
//  pc_write     out  1     unconditional PC load
//  branch       out  1     PC load if ALU zero
//  pc_src       out  2     00 ALUResult, 01 ALUOut, 10 jump target
//  alu_src_a    out  1     0 PC, 1 A
//  alu_src_b    out  2     00 B, 01 const 4, 10 SignImm, 11 SignImm<<2
//  alu_ctrl     out  3     010 add, 110 sub, 000 and, 001 or, 111 slt
//  reg_dst      out  1     0 rt, 1 rd
//  mem_to_reg   out  1     0 ALUOut, 1 mem data
//  reg_write    out  1     register-file write enable
//  illegal_op   out  1     1-cycle pulse on unsupported opcode/funct
//  state_o      out  4     current state (debug)
//  instr_count  out  CNT_WIDTH  retired instructions
// BEHAVIOUR
//  - rst: state<=FETCH, instr_count<=0; while rst high all control outputs forced 0.
//  - Outputs decoded from state only (Moore); unlisted outputs are 0 in each state.
//  - FETCH: mem_read, iord=0, src_a=0, src_b=01, add; ir_write=pc_write=mem_ready;
//    holds until mem_ready, then DECODE.
//  - DECODE: src_a=0, src_b=11, add (branch target into ALUOut). Next by opcode:
//    100011 lw / 101011 sw->MEMADR, 000000->RTYPEEX, 000100->BEQEX,
//    001000->ADDIEX, 000010->JEX; else illegal_op=1, ->FETCH, not counted.
//  - MEMADR: src_a=1, src_b=10, add; ->MEMRD (lw) or MEMWR (sw).
//  - MEMRD: mem_read, iord=1; hold until mem_ready ->MEMWB.
//  - MEMWB: reg_write, mem_to_reg=1, reg_dst=0; ->FETCH.
//  - MEMWR: mem_write, iord=1; hold until mem_ready ->FETCH.
//  - RTYPEEX: src_a=1, src_b=00, alu_ctrl from funct (100000 add, 100010 sub,
//    100100 and, 100101 or, 101010 slt) ->RTYPEWB; other funct: illegal_op, ->FETCH.
//  - RTYPEWB: reg_write, reg_dst=1, mem_to_reg=0; ->FETCH.
//  - BEQEX: src_a=1, src_b=00, sub, branch=1, pc_src=01; ->FETCH.
//  - ADDIEX: src_a=1, src_b=10, add ->ADDIWB: reg_write, reg_dst=0 ->FETCH.
//  - JEX: pc_write=1, pc_src=10; ->FETCH.
//  - instr_count += 1 on every legal transition into FETCH (MEMWB, MEMWR w/ ready,
//    RTYPEWB, BEQEX, ADDIWB, JEX); wraps at 2^CNT_WIDTH. Latencies: lw 5, sw 4,
//    R 4, addi 4, beq 3, j 3 cycles with zero-wait memory; +1 per stall cycle.
//  - mem_ready outside FETCH/MEMRD/MEMWR ignored. Unused state codes ->FETCH.
//  - rst mid-instruction: immediate return to FETCH, no write strobe glitches out.
// STRUCTURE
//  - MIPS_pkg gains: mips_opcode_t, mips_funct_t, opcode/funct constants,
//    alu_ctrl_t enum, ctrl_state_t enum (4-bit), src-select enums.
//  - Sub-module mips_alu_decoder: combinational funct/state -> alu_ctrl + illegal.
// TESTING
//  - lw, mem_ready tied 1 -> FETCH,DECODE,MEMADR,MEMRD,MEMWB; one reg_write, count 0->1.
//  - sw with mem_ready low 3 cycles in MEMWR -> mem_write held 4 cycles, no reg_write.
//  - R-type funct 100010 -> alu_ctrl=110 in RTYPEEX, reg_dst=1 in RTYPEWB.
//  - opcode 111111 -> illegal_op pulse in DECODE, back to FETCH, count unchanged.
//  - beq then j -> branch=1 pc_src=01 in BEQEX; pc_write=1 pc_src=10 in JEX; 3 cycles each.
//  - rst asserted in MEMRD -> all outputs 0 same cycle, FETCH after release, count 0.

Source files
------------

// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control unit:
// opcode/funct constants, ALU control codes, FSM states and mux selects.
package mips_multicycle_ctrl_pkg;

  typedef logic [5:0] mips_opcode_t;
  typedef logic [5:0] mips_funct_t;

  localparam mips_opcode_t OP_RTYPE = 6'b000000;
  localparam mips_opcode_t OP_LW    = 6'b100011;
  localparam mips_opcode_t OP_SW    = 6'b101011;
  localparam mips_opcode_t OP_BEQ   = 6'b000100;
  localparam mips_opcode_t OP_ADDI  = 6'b001000;
  localparam mips_opcode_t OP_J     = 6'b000010;

  localparam mips_funct_t FN_ADD = 6'b100000;
  localparam mips_funct_t FN_SUB = 6'b100010;
  localparam mips_funct_t FN_AND = 6'b100100;
  localparam mips_funct_t FN_OR  = 6'b100101;
  localparam mips_funct_t FN_SLT = 6'b101010;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_ctrl_t;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } ctrl_state_t;

  typedef enum logic {
    SRCA_PC = 1'b0,
    SRCA_A  = 1'b1
  } src_a_t;

  typedef enum logic [1:0] {
    SRCB_B       = 2'b00,
    SRCB_FOUR    = 2'b01,
    SRCB_IMM     = 2'b10,
    SRCB_IMM_SH2 = 2'b11
  } src_b_t;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10
  } pc_src_t;

endpackage

// File: rtl/mips_multicycle_ctrl_alu_decoder.sv
// ALU control decode: fixed operation for address/PC states, funct-driven
// operation in RTYPEEX, with an illegal flag for unsupported funct codes.
module mips_alu_decoder
  import mips_multicycle_ctrl_pkg::*;
(
  input  ctrl_state_t state_i,
  input  mips_funct_t funct_i,
  output alu_ctrl_t   alu_ctrl_o,
  output logic        illegal_funct_o
);

  // Select the ALU operation for the current state
  always_comb begin
    alu_ctrl_o      = ALU_AND;
    illegal_funct_o = 1'b0;
    case (state_i)
      S_FETCH, S_DECODE, S_MEMADR, S_ADDIEX: alu_ctrl_o = ALU_ADD;
      S_BEQEX:                               alu_ctrl_o = ALU_SUB;
      S_RTYPEEX: begin
        case (funct_i)
          FN_ADD:  alu_ctrl_o = ALU_ADD;
          FN_SUB:  alu_ctrl_o = ALU_SUB;
          FN_AND:  alu_ctrl_o = ALU_AND;
          FN_OR:   alu_ctrl_o = ALU_OR;
          FN_SLT:  alu_ctrl_o = ALU_SLT;
          default: illegal_funct_o = 1'b1;
        endcase
      end
      default: alu_ctrl_o = ALU_AND;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Moore control FSM of the multi-cycle MIPS core: sequences fetch, decode,
// execute and writeback over a shared datapath and counts retired instructions.
module mips_multicycle_ctrl
  import mips_multicycle_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [5:0]           opcode,
  input  logic [5:0]           funct,
  input  logic                 mem_ready,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 iord,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 branch,
  output logic [1:0]           pc_src,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [2:0]           alu_ctrl,
  output logic                 reg_dst,
  output logic                 mem_to_reg,
  output logic                 reg_write,
  output logic                 illegal_op,
  output logic [3:0]           state_o,
  output logic [CNT_WIDTH-1:0] instr_count
);

  ctrl_state_t          state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  alu_ctrl_t            dec_alu_s;
  logic                 dec_illegal_s;
  logic                 retire_s;

  mips_alu_decoder u_alu_dec (
    .state_i        (state_q),
    .funct_i        (funct),
    .alu_ctrl_o     (dec_alu_s),
    .illegal_funct_o(dec_illegal_s)
  );

  // State and retired-instruction counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic and Moore control outputs
  always_comb begin
    state_d    = S_FETCH;
    retire_s   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    pc_src     = PCSRC_ALU;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_B;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    illegal_op = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        state_d   = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH2;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JEX;
          default: begin
            illegal_op = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRCA_A;
        alu_src_b = SRCB_IMM;
        state_d   = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        state_d  = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire_s   = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        retire_s  = mem_ready;
        state_d   = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_RTYPEEX: begin
        alu_src_a  = SRCA_A;
        alu_src_b  = SRCB_B;
        illegal_op = dec_illegal_s;
        state_d    = dec_illegal_s ? S_FETCH : S_RTYPEWB;
      end
      S_RTYPEWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire_s  = 1'b1;
      end
      S_BEQEX: begin
        alu_src_a = SRCA_A;
        alu_src_b = SRCB_B;
        branch    = 1'b1;
        pc_src    = PCSRC_ALUOUT;
        retire_s  = 1'b1;
      end
      S_ADDIEX: begin
        alu_src_a = SRCA_A;
        alu_src_b = SRCB_IMM;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
        retire_s  = 1'b1;
      end
      S_JEX: begin
        pc_write = 1'b1;
        pc_src   = PCSRC_JUMP;
        retire_s = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase

    alu_ctrl = dec_alu_s;
    cnt_d    = retire_s ? cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1} : cnt_q;

    // Reset gates every strobe so nothing reaches memory or the register file
    if (rst) begin
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      iord       = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      branch     = 1'b0;
      pc_src     = 2'b00;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_ctrl   = 3'b000;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      illegal_op = 1'b0;
    end else begin
      alu_ctrl = dec_alu_s;
    end
  end

  assign state_o     = state_q;
  assign instr_count = cnt_q;

endmodule
